// File: rtl/ahb_dm_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_dm_slave_if
// AHB-Lite bus bundle between one master (or the bus fabric) and the
// data-memory slave front-end.
//
// Signals:
//   HSEL      slave select
//   HADDR     32-bit byte address (address phase)
//   HTRANS    transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HWRITE    1 = write
//   HSIZE     transfer size: 0 byte, 1 halfword, 2 word
//   HWDATA    write data, valid in the data phase
//   HREADYIN  bus-level HREADY as seen by the slave
//   HREADYOUT slave ready
//   HRESP     0 OKAY, 1 ERROR
//   HRDATA    read data
//
// Modports:
//   master  drives the request side and observes the response
//   slave   observes the request side and drives the response
// ---------------------------------------------------------------------------
interface ahb_dm_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_dm_slave.sv
// ---------------------------------------------------------------------------
// ahb_dm_slave
// AHB-Lite slave front-end placed directly in front of the data memory (DM).
// Converts bus transfers into DM word accesses, performs read-modify-write
// for byte and halfword stores, inserts WAIT_STATES data-phase wait cycles
// per accepted transfer and produces the two-cycle ERROR response for
// illegal transfers.
//
// Parameters:
//   WAIT_STATES  data-phase wait cycles per accepted transfer (0..7)
//   DM_AW        DM word-address width; HADDR[DM_AW+1:2] is decoded
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   bus         AHB-Lite slave modport (HSEL..HRDATA)
//   DM_enable   DM access active (every DATA cycle)
//   DM_write    DM write strobe (final DATA cycle of a write only)
//   DM_address  DM word address
//   DM_in       merged write word (new bytes over the current DM word)
//   DM_out      DM combinational read word
// ---------------------------------------------------------------------------
module ahb_dm_slave #(
    parameter int WAIT_STATES = 0,
    parameter int DM_AW       = 16
) (
    input  logic              clk,
    input  logic              rst,
    ahb_dm_slave_if.slave     bus,
    output logic              DM_enable,
    output logic              DM_write,
    output logic [DM_AW-1:0]  DM_address,
    output logic [31:0]       DM_in,
    input  logic [31:0]       DM_out
);

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    state_t           state, state_next;
    logic [2:0]       wait_cnt, wait_cnt_next;
    logic [DM_AW-1:0] addr_reg, addr_next;
    logic             write_reg, write_next;
    logic [3:0]       mask_reg, mask_next;

    logic             illegal;
    logic [3:0]       lane_mask;
    logic             final_cycle;
    logic             can_accept;
    logic             accept;

    // Address-phase decode: little-endian byte-lane mask for the requested
    // size, plus the illegal-transfer check (bad size, misalignment, or an
    // address beyond the DM window). The window check shifts instead of
    // slicing so it stays valid for any DM_AW.
    always_comb begin
        illegal   = 1'b0;
        lane_mask = 4'b0000;
        case (bus.HSIZE)
            3'd0: lane_mask = 4'b0001 << bus.HADDR[1:0];
            3'd1: begin
                lane_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
                illegal   = bus.HADDR[0];
            end
            3'd2: begin
                lane_mask = 4'b1111;
                illegal   = (bus.HADDR[1:0] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        if ((bus.HADDR >> (DM_AW + 2)) != 32'd0) begin
            illegal = 1'b1;
        end
    end

    // A new address phase may only be taken when the slave is not stalling
    // the bus: in IDLE, in the last DATA cycle, or in ERR2. During ERR1 the
    // address phase is deliberately ignored and must be re-presented.
    assign final_cycle = (state == DATA) && (wait_cnt == 3'd0);
    assign can_accept  = (state == IDLE) || final_cycle || (state == ERR2);
    assign accept      = can_accept && bus.HSEL && bus.HTRANS[1] && bus.HREADYIN;

    // State and transfer-attribute registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            mask_reg  <= 4'b0000;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            addr_reg  <= addr_next;
            write_reg <= write_next;
            mask_reg  <= mask_next;
        end
    end

    // Next-state and output logic. Outputs are forced to their idle values
    // while rst is high so that a reset landing on the final cycle of a
    // write cannot leak a DM_write into memory.
    always_comb begin
        state_next    = IDLE;
        wait_cnt_next = wait_cnt;
        addr_next     = addr_reg;
        write_next    = write_reg;
        mask_next     = mask_reg;

        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = 32'd0;
        DM_enable     = 1'b0;
        DM_write      = 1'b0;
        DM_address    = '0;
        DM_in         = 32'd0;

        case (state)
            DATA: begin
                if (wait_cnt != 3'd0) begin
                    state_next    = DATA;
                    wait_cnt_next = wait_cnt - 3'd1;
                end
            end
            ERR1: state_next = ERR2;
            default: ;
        endcase

        if (accept) begin
            if (illegal) begin
                state_next = ERR1;
            end else begin
                state_next    = DATA;
                wait_cnt_next = WAIT_INIT;
                addr_next     = bus.HADDR[DM_AW+1:2];
                write_next    = bus.HWRITE;
                mask_next     = lane_mask;
            end
        end

        if (!rst) begin
            case (state)
                DATA: begin
                    DM_enable     = 1'b1;
                    DM_address    = addr_reg;
                    bus.HREADYOUT = final_cycle;
                    if (write_reg) begin
                        // Read-modify-write: unselected lanes keep the
                        // current DM contents.
                        for (int i = 0; i < 4; i++) begin
                            DM_in[8*i +: 8] = mask_reg[i] ? bus.HWDATA[8*i +: 8]
                                                          : DM_out[8*i +: 8];
                        end
                        DM_write = final_cycle;
                    end else if (final_cycle) begin
                        bus.HRDATA = DM_out;
                    end
                end
                ERR1: begin
                    bus.HREADYOUT = 1'b0;
                    bus.HRESP     = 1'b1;
                end
                ERR2: begin
                    bus.HRESP = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dm_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_dm_slave
// Directed bench for ahb_dm_slave. Three instances (WAIT_STATES 0, 2, 3),
// each with its own bus interface and a behavioural data memory, share one
// set of stimulus signals; "sel" picks which instance sees HSEL.
// Inputs change 1 time unit after the rising edge, outputs are checked at
// the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_dm_slave;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = T_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'd0;

    logic        o_ready [3];
    logic        o_resp  [3];
    logic        o_en    [3];
    logic        o_wr    [3];
    logic [31:0] o_rdata [3];
    logic [31:0] o_din   [3];
    logic [15:0] o_addr  [3];

    int n_asserts = 0;
    int n_fails   = 0;

    logic [31:0] err_addr [4];
    logic [2:0]  err_size [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_dm_slave_if bus ();
        logic [31:0] mem [0:65535];
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] din;
        logic [31:0] dout;

        assign bus.HSEL     = (sel == g) && hsel;
        assign bus.HADDR    = haddr;
        assign bus.HTRANS   = htrans;
        assign bus.HWRITE   = hwrite;
        assign bus.HSIZE    = hsize;
        assign bus.HWDATA   = hwdata;
        assign bus.HREADYIN = bus.HREADYOUT;

        // Data memory: combinational read, synchronous full-word write.
        assign dout = mem[addr];
        always @(posedge clk) begin
            if (wr) mem[addr] <= din;
        end

        ahb_dm_slave #(
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
            .DM_AW      (16)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus),
            .DM_enable (en),
            .DM_write  (wr),
            .DM_address(addr),
            .DM_in     (din),
            .DM_out    (dout)
        );

        assign o_ready[g] = bus.HREADYOUT;
        assign o_resp[g]  = bus.HRESP;
        assign o_rdata[g] = bus.HRDATA;
        assign o_en[g]    = en;
        assign o_wr[g]    = wr;
        assign o_addr[g]  = addr;
        assign o_din[g]   = din;
    end

    // One bus cycle: wait for the edge, drive the new inputs, then return at
    // the falling edge where outputs are checked.
    task automatic applyStimulus(input int s, input logic hs, input logic [1:0] ht,
                                 input logic hw, input logic [2:0] hz,
                                 input logic [31:0] ha, input logic [31:0] hd,
                                 input logic r);
        @(posedge clk);
        #1;
        sel    = s;
        hsel   = hs;
        htrans = ht;
        hwrite = hw;
        hsize  = hz;
        haddr  = ha;
        hwdata = hd;
        rst    = r;
        #4;
    endtask

    task automatic xfer(input int s, input logic hw, input logic [2:0] hz,
                        input logic [31:0] ha, input logic [31:0] hd);
        applyStimulus(s, 1'b1, T_NONSEQ, hw, hz, ha, hd, 1'b0);
    endtask

    task automatic idleCycle(input int s, input logic [31:0] hd);
        applyStimulus(s, 1'b0, T_IDLE, 1'b0, 3'd0, 32'd0, hd, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        err_addr = '{32'h0000_0042, 32'h0000_0043, 32'h0000_0040, 32'h0004_0000};
        err_size = '{3'd2, 3'd1, 3'd3, 3'd2};

        // Reset, then every instance must sit at its reset values.
        applyStimulus(0, 1'b0, T_IDLE, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        applyStimulus(0, 1'b0, T_IDLE, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        idleCycle(0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset hreadyout", 32'(o_ready[k]), 32'd1);
            checkOutput("reset hresp", 32'(o_resp[k]), 32'd0);
            checkOutput("reset hrdata", o_rdata[k], 32'd0);
            checkOutput("reset dm_enable", 32'(o_en[k]), 32'd0);
            checkOutput("reset dm_write", 32'(o_wr[k]), 32'd0);
            checkOutput("reset dm_address", 32'(o_addr[k]), 32'd0);
            checkOutput("reset dm_in", o_din[k], 32'd0);
        end

        $display("[TB] zero-wait word write/read");
        xfer(0, 1'b1, 3'd2, 32'h10, 32'd0);
        checkOutput("ws0 addr phase ready", 32'(o_ready[0]), 32'd1);
        checkOutput("ws0 addr phase enable", 32'(o_en[0]), 32'd0);
        xfer(0, 1'b0, 3'd2, 32'h10, 32'hDEAD_BEEF);
        checkOutput("ws0 wr enable", 32'(o_en[0]), 32'd1);
        checkOutput("ws0 wr strobe", 32'(o_wr[0]), 32'd1);
        checkOutput("ws0 wr address", 32'(o_addr[0]), 32'd4);
        checkOutput("ws0 wr dm_in", o_din[0], 32'hDEAD_BEEF);
        checkOutput("ws0 wr ready", 32'(o_ready[0]), 32'd1);
        idleCycle(0, 32'd0);
        checkOutput("ws0 rd data", o_rdata[0], 32'hDEAD_BEEF);
        checkOutput("ws0 rd ready", 32'(o_ready[0]), 32'd1);
        checkOutput("ws0 rd no strobe", 32'(o_wr[0]), 32'd0);
        idleCycle(0, 32'd0);
        checkOutput("ws0 idle enable", 32'(o_en[0]), 32'd0);
        checkOutput("ws0 idle rdata", o_rdata[0], 32'd0);

        $display("[TB] byte and halfword read-modify-write");
        xfer(0, 1'b1, 3'd2, 32'h20, 32'd0);
        xfer(0, 1'b1, 3'd0, 32'h22, 32'h1122_3344);
        checkOutput("rmw word dm_in", o_din[0], 32'h1122_3344);
        xfer(0, 1'b1, 3'd1, 32'h20, 32'h00AA_0000);
        checkOutput("rmw byte dm_in", o_din[0], 32'h11AA_3344);
        checkOutput("rmw byte address", 32'(o_addr[0]), 32'd8);
        xfer(0, 1'b0, 3'd2, 32'h20, 32'h0000_BEEF);
        checkOutput("rmw half dm_in", o_din[0], 32'h11AA_BEEF);
        checkOutput("rmw half strobe", 32'(o_wr[0]), 32'd1);
        idleCycle(0, 32'd0);
        checkOutput("rmw readback", o_rdata[0], 32'h11AA_BEEF);

        $display("[TB] pipelined write then read, BUSY ignored");
        xfer(0, 1'b1, 3'd2, 32'h40, 32'd0);
        xfer(0, 1'b0, 3'd2, 32'h40, 32'h0000_0005);
        checkOutput("pipe wr strobe", 32'(o_wr[0]), 32'd1);
        idleCycle(0, 32'd0);
        checkOutput("pipe rd data", o_rdata[0], 32'h0000_0005);
        applyStimulus(0, 1'b1, T_BUSY, 1'b1, 3'd2, 32'h40, 32'd0, 1'b0);
        idleCycle(0, 32'd0);
        checkOutput("busy no enable", 32'(o_en[0]), 32'd0);
        checkOutput("busy ready", 32'(o_ready[0]), 32'd1);
        checkOutput("busy okay", 32'(o_resp[0]), 32'd0);

        $display("[TB] illegal transfers");
        for (int e = 0; e < 4; e++) begin
            xfer(0, 1'b1, err_size[e], err_addr[e], 32'd0);
            idleCycle(0, 32'hFFFF_FFFF);
            checkOutput("err1 ready", 32'(o_ready[0]), 32'd0);
            checkOutput("err1 resp", 32'(o_resp[0]), 32'd1);
            checkOutput("err1 enable", 32'(o_en[0]), 32'd0);
            checkOutput("err1 strobe", 32'(o_wr[0]), 32'd0);
            idleCycle(0, 32'hFFFF_FFFF);
            checkOutput("err2 ready", 32'(o_ready[0]), 32'd1);
            checkOutput("err2 resp", 32'(o_resp[0]), 32'd1);
            checkOutput("err2 strobe", 32'(o_wr[0]), 32'd0);
            idleCycle(0, 32'd0);
            checkOutput("err after resp", 32'(o_resp[0]), 32'd0);
        end
        xfer(0, 1'b0, 3'd2, 32'h40, 32'd0);
        idleCycle(0, 32'd0);
        checkOutput("err mem untouched", o_rdata[0], 32'h0000_0005);

        $display("[TB] two wait states");
        xfer(1, 1'b1, 3'd2, 32'h30, 32'd0);
        checkOutput("ws2 addr ready", 32'(o_ready[1]), 32'd1);
        xfer(1, 1'b0, 3'd2, 32'h30, 32'hCAFE_F00D);
        checkOutput("ws2 wr c1 ready", 32'(o_ready[1]), 32'd0);
        checkOutput("ws2 wr c1 strobe", 32'(o_wr[1]), 32'd0);
        checkOutput("ws2 wr c1 enable", 32'(o_en[1]), 32'd1);
        checkOutput("ws2 wr c1 address", 32'(o_addr[1]), 32'd12);
        xfer(1, 1'b0, 3'd2, 32'h30, 32'hCAFE_F00D);
        checkOutput("ws2 wr c2 ready", 32'(o_ready[1]), 32'd0);
        checkOutput("ws2 wr c2 strobe", 32'(o_wr[1]), 32'd0);
        xfer(1, 1'b0, 3'd2, 32'h30, 32'hCAFE_F00D);
        checkOutput("ws2 wr c3 ready", 32'(o_ready[1]), 32'd1);
        checkOutput("ws2 wr c3 strobe", 32'(o_wr[1]), 32'd1);
        checkOutput("ws2 wr c3 dm_in", o_din[1], 32'hCAFE_F00D);
        idleCycle(1, 32'd0);
        checkOutput("ws2 rd c1 ready", 32'(o_ready[1]), 32'd0);
        checkOutput("ws2 rd c1 rdata", o_rdata[1], 32'd0);
        idleCycle(1, 32'd0);
        checkOutput("ws2 rd c2 ready", 32'(o_ready[1]), 32'd0);
        idleCycle(1, 32'd0);
        checkOutput("ws2 rd c3 ready", 32'(o_ready[1]), 32'd1);
        checkOutput("ws2 rd c3 rdata", o_rdata[1], 32'hCAFE_F00D);
        checkOutput("ws2 rd c3 strobe", 32'(o_wr[1]), 32'd0);
        idleCycle(1, 32'd0);
        checkOutput("ws2 idle ready", 32'(o_ready[1]), 32'd1);

        $display("[TB] reset during a three-wait-state write");
        xfer(2, 1'b1, 3'd2, 32'h50, 32'd0);
        for (int c = 0; c < 4; c++) idleCycle(2, 32'h0BAD_CAFE);
        idleCycle(2, 32'd0);
        checkOutput("ws3 prefill", g_dut[2].mem[20], 32'h0BAD_CAFE);
        xfer(2, 1'b1, 3'd2, 32'h50, 32'd0);
        idleCycle(2, 32'h1234_5678);
        checkOutput("ws3 wait1 ready", 32'(o_ready[2]), 32'd0);
        applyStimulus(2, 1'b0, T_IDLE, 1'b0, 3'd0, 32'd0, 32'h1234_5678, 1'b1);
        checkOutput("ws3 rst cycle strobe", 32'(o_wr[2]), 32'd0);
        idleCycle(2, 32'h1234_5678);
        checkOutput("ws3 post rst ready", 32'(o_ready[2]), 32'd1);
        checkOutput("ws3 post rst resp", 32'(o_resp[2]), 32'd0);
        checkOutput("ws3 post rst enable", 32'(o_en[2]), 32'd0);
        checkOutput("ws3 post rst strobe", 32'(o_wr[2]), 32'd0);
        checkOutput("ws3 post rst address", 32'(o_addr[2]), 32'd0);
        checkOutput("ws3 post rst dm_in", o_din[2], 32'd0);
        checkOutput("ws3 post rst rdata", o_rdata[2], 32'd0);
        idleCycle(2, 32'd0);
        checkOutput("ws3 mem unchanged", g_dut[2].mem[20], 32'h0BAD_CAFE);
        xfer(2, 1'b0, 3'd2, 32'h50, 32'd0);
        for (int c = 0; c < 3; c++) begin
            idleCycle(2, 32'd0);
            checkOutput("ws3 rd wait ready", 32'(o_ready[2]), 32'd0);
        end
        idleCycle(2, 32'd0);
        checkOutput("ws3 rd final ready", 32'(o_ready[2]), 32'd1);
        checkOutput("ws3 rd final rdata", o_rdata[2], 32'h0BAD_CAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
